// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-master round-robin Wishbone classic arbiter
//
// Shares one 32-bit Wishbone slave between master 0 (AXI bridge) and
// master 1 (debug/DMA). The grant is held for the whole CYC window, so
// multi-beat sequences issued under one CYC are atomic.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN (stalled-access watchdog).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mX_adr/dat/sel/we/cyc/stb  master X request
//   o_mX_rdt/ack/err             master X response
//   o_s_adr/dat/sel/we/cyc/stb   slave request
//   i_s_rdt/ack/err              slave response
//   o_grant                      one-hot grant, 2'b00 when idle
//   o_timeout                    one-cycle pulse when the watchdog fires
module wb_rr_arbiter #(
  parameter int ADR_W     = 10,
  parameter int TO_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ADR_W-1:0] i_m0_adr,
  input  logic [31:0]      i_m0_dat,
  input  logic [3:0]       i_m0_sel,
  input  logic             i_m0_we,
  input  logic             i_m0_cyc,
  input  logic             i_m0_stb,
  input  logic [ADR_W-1:0] i_m1_adr,
  input  logic [31:0]      i_m1_dat,
  input  logic [3:0]       i_m1_sel,
  input  logic             i_m1_we,
  input  logic             i_m1_cyc,
  input  logic             i_m1_stb,
  output logic [31:0]      o_m0_rdt,
  output logic             o_m0_ack,
  output logic             o_m0_err,
  output logic [31:0]      o_m1_rdt,
  output logic             o_m1_ack,
  output logic             o_m1_err,
  output logic [ADR_W-1:0] o_s_adr,
  output logic [31:0]      o_s_dat,
  output logic [3:0]       o_s_sel,
  output logic             o_s_we,
  output logic             o_s_cyc,
  output logic             o_s_stb,
  input  logic [31:0]      i_s_rdt,
  input  logic             i_s_ack,
  input  logic             i_s_err,
  output logic [1:0]       o_grant,
  output logic             o_timeout
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t state, state_next;
  logic   last, last_next;      // index of the master released most recently
  logic   granted_cyc, granted_stb;
  logic   masked;               // access killed by the watchdog, until cyc drops
  logic   timeout;
  logic   ack_ok, err_ok;

  assign o_grant  = state;
  assign o_m0_rdt = i_s_rdt;
  assign o_m1_rdt = i_s_rdt;

  assign granted_cyc = (state == G0) ? i_m0_cyc : (state == G1) ? i_m1_cyc : 1'b0;
  assign granted_stb = (state == G0) ? i_m0_stb : (state == G1) ? i_m1_stb : 1'b0;
  assign ack_ok      = i_s_ack & ~masked;
  assign err_ok      = i_s_err & ~masked;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_next = last ? G0 : G1;
        else if (i_m0_cyc)        state_next = G0;
        else if (i_m1_cyc)        state_next = G1;
      end
      G0: begin
        if (!i_m0_cyc) begin
          last_next  = 1'b0;
          state_next = i_m1_cyc ? G1 : IDLE;
        end
      end
      G1: begin
        if (!i_m1_cyc) begin
          last_next  = 1'b1;
          state_next = i_m0_cyc ? G0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: slave-side mux and response routing
  always_comb begin
    o_s_adr  = '0;
    o_s_dat  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    case (state)
      G0: begin
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_s_cyc  = i_m0_cyc & ~masked;
        o_s_stb  = i_m0_stb & ~masked;
        o_m0_ack = ack_ok;
        o_m0_err = err_ok | timeout;
      end
      G1: begin
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_s_cyc  = i_m1_cyc & ~masked;
        o_s_stb  = i_m1_stb & ~masked;
        o_m1_ack = ack_ok;
        o_m1_err = err_ok | timeout;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

  logic [15:0] cnt;

  // cnt holds the number of earlier stalled strobe cycles, so the check
  // against TO_CYCLES-1 fires in the TO_CYCLES-th stalled cycle. A same-cycle
  // ack or err takes priority over the timeout.
  assign timeout = granted_stb & ~masked & ~i_s_ack & ~i_s_err & (cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      masked <= 1'b0;
    end else begin
      if (!granted_stb || masked || i_s_ack || i_s_err || timeout) cnt <= '0;
      else                                                         cnt <= cnt + 16'd1;
      // Release (cyc low) always lifts the mask, including on handover.
      if (!granted_cyc)  masked <= 1'b0;
      else if (timeout)  masked <= 1'b1;
    end
  end
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES == 0);
  assign timeout          = 1'b0;
  assign masked           = 1'b0;
`endif

  assign o_timeout = timeout;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

  localparam int ADR_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [ADR_W-1:0] m0_adr, m1_adr;
  logic [31:0]      m0_dat, m1_dat;
  logic [3:0]       m0_sel, m1_sel;
  logic             m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [31:0]      m0_rdt, m1_rdt;
  logic             m0_ack, m1_ack, m0_err, m1_err;
  logic [ADR_W-1:0] s_adr;
  logic [31:0]      s_dat, s_rdt;
  logic [3:0]       s_sel;
  logic             s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]       grant;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.ADR_W(ADR_W), .TO_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
    .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(grant), .o_timeout(timeout)
  );

  typedef struct {
    logic       rst, c0, s0, c1, s1, ack, err;
    logic [1:0] g;
    logic       scyc, sstb, a0, a1, e0, e1;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] g;
    logic       scyc, sstb, a0, a1, e0, e1, we;
    logic [31:0] adr, dat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic add(input logic rst_i, c0, s0, c1, s1, ack, err,
                     input logic [1:0] g, input logic scyc, sstb, a0, a1, e0, e1);
    vec_t v;
    v = '{rst_i, c0, s0, c1, s1, ack, err, g, scyc, sstb, a0, a1, e0, e1};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  initial begin
    exp_t e;
    m0_adr = 10'h010; m0_dat = 32'hA5A5_0001; m0_sel = 4'hF; m0_we = 1'b1;
    m1_adr = 10'h055; m1_dat = 32'h1234_5678; m1_sel = 4'h3; m1_we = 1'b0;
    s_rdt  = 32'hDEAD_BEEF;
    idle_inputs();
    rst = 1'b1;

    //   rst c0 s0 c1 s1 ack err   g     scyc sstb a0 a1 e0 e1
    add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // reset state
    add(0, 1, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0); // ack while idle ignored
    add(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0); // ack 2 cycles after stb
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // last back to 1
    add(0, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // tie
    add(0, 1, 1, 1, 1, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0); // m0 first
    add(0, 1, 1, 1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0); // handover, no gap
    add(0, 0, 0, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // short m0 cycle -> last=0
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // repeat tie
    add(0, 1, 0, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0); // m1 first
    add(0, 1, 0, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // reset mid-transfer
    add(0, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0); // late ack dropped
    add(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); // error pass-through
    add(0, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1, 2'b10, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0); // err while idle ignored

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; s_ack = tbl[i].ack; s_err = tbl[i].err;
      e.idx = i; e.g = tbl[i].g; e.scyc = tbl[i].scyc; e.sstb = tbl[i].sstb;
      e.a0 = tbl[i].a0; e.a1 = tbl[i].a1; e.e0 = tbl[i].e0; e.e1 = tbl[i].e1;
      e.adr = (tbl[i].g == 2'b01) ? 32'(m0_adr) : (tbl[i].g == 2'b10) ? 32'(m1_adr) : 32'h0;
      e.dat = (tbl[i].g == 2'b01) ? m0_dat : (tbl[i].g == 2'b10) ? m1_dat : 32'h0;
      e.we  = (tbl[i].g == 2'b01) ? m0_we : (tbl[i].g == 2'b10) ? m1_we : 1'b0;
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", i, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("grant",  e.idx, 32'(grant),  32'(e.g));
        chk("s_cyc",  e.idx, 32'(s_cyc),  32'(e.scyc));
        chk("s_stb",  e.idx, 32'(s_stb),  32'(e.sstb));
        chk("m0_ack", e.idx, 32'(m0_ack), 32'(e.a0));
        chk("m1_ack", e.idx, 32'(m1_ack), 32'(e.a1));
        chk("m0_err", e.idx, 32'(m0_err), 32'(e.e0));
        chk("m1_err", e.idx, 32'(m1_err), 32'(e.e1));
        chk("s_adr",  e.idx, 32'(s_adr),  e.adr);
        chk("s_dat",  e.idx, s_dat,       e.dat);
        chk("s_we",   e.idx, 32'(s_we),   32'(e.we));
        chk("m0_rdt", e.idx, m0_rdt,      32'hDEAD_BEEF);
        chk("timeout", e.idx, 32'(timeout), 32'd0);
      end
    end

    // Atomic two-beat read by m0 while m1 waits (last=1, so m0 wins the tie).
    @(negedge clk);
    idle_inputs();
    m0_adr = 10'h020; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1 chk("at_grant", 0, 32'(grant), 32'h0);
    @(negedge clk); s_ack = 1'b1;
    #1 chk("at_grant", 1, 32'(grant), 32'h1);
    chk("at_adr", 1, 32'(s_adr), 32'h020);
    chk("at_ack0", 1, 32'(m0_ack), 32'h1);
    chk("at_ack1", 1, 32'(m1_ack), 32'h0);
    @(negedge clk); s_ack = 1'b0; m0_stb = 1'b0;
    #1 chk("at_grant", 2, 32'(grant), 32'h1);
    chk("at_stb", 2, 32'(s_stb), 32'h0);
    chk("at_cyc", 2, 32'(s_cyc), 32'h1);
    @(negedge clk); m0_stb = 1'b1; m0_adr = 10'h021; s_ack = 1'b1;
    #1 chk("at_grant", 3, 32'(grant), 32'h1);
    chk("at_adr", 3, 32'(s_adr), 32'h021);
    chk("at_ack0", 3, 32'(m0_ack), 32'h1);
    chk("at_ack1", 3, 32'(m1_ack), 32'h0);
    @(negedge clk); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1 chk("at_grant", 4, 32'(grant), 32'h1);
    @(negedge clk);
    #1 chk("at_grant", 5, 32'(grant), 32'h2);
    chk("at_adr", 5, 32'(s_adr), 32'(m1_adr));
    chk("at_cyc", 5, 32'(s_cyc), 32'h1);
    @(negedge clk); m1_cyc = 1'b0; m1_stb = 1'b0;
    @(negedge clk);
    #1 chk("at_idle", 6, 32'(grant), 32'h0);

    // Stalled slave: m0 strobes for 10 cycles without a response.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      idle_inputs();
      m0_cyc = 1'b1; m0_stb = 1'b1;
      #1 chk("wd_idle", pass, 32'(grant), 32'h0);
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        s_ack = (pass == 1 && k == 8) || (pass == 0 && k == 9);
`ifdef WB_ARB_TIMEOUT_EN
        #1;
        if (k < 8) begin
          chk("wd_err_early", k, 32'(m0_err), 32'h0);
          chk("wd_tmo_early", k, 32'(timeout), 32'h0);
          chk("wd_cyc_early", k, 32'(s_cyc), 32'h1);
        end else if (k == 8) begin
          chk("wd_ack8", pass, 32'(m0_ack), 32'(pass));
          chk("wd_err8", pass, 32'(m0_err), 32'(1 - pass));
          chk("wd_tmo8", pass, 32'(timeout), 32'(1 - pass));
          chk("wd_err8_m1", pass, 32'(m1_err), 32'h0);
        end else if (pass == 0) begin
          chk("wd_mask_cyc", k, 32'(s_cyc), 32'h0);
          chk("wd_mask_stb", k, 32'(s_stb), 32'h0);
          chk("wd_mask_ack", k, 32'(m0_ack), 32'h0);
          chk("wd_tmo_after", k, 32'(timeout), 32'h0);
        end
`else
        #1;
        chk("stall_tmo", k, 32'(timeout), 32'h0);
        chk("stall_cyc", k, 32'(s_cyc), 32'h1);
        chk("stall_err", k, 32'(m0_err), 32'h0);
`endif
        if (pass == 1 && k == 8) begin
          @(negedge clk);
          s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
          break;
        end
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      #1 chk("wd_release", pass, 32'(grant), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
